// File: rtl/pong_score_controller_if.sv
// Signal bundle between the Pong match sequencer and its neighbours:
// point/start pulses come in from the ball logic, score and status
// signals go out to the display driver and ball logic.
//
// Handshake: there is no valid/ready pair on this bundle. start,
// point_left and point_right are single-cycle pulses sampled on the
// rising clock edge. Every output is a registered level that changes
// only on a clock edge, or on reset assertion.
interface pong_score_controller_if;
  logic       start;
  logic       point_left;
  logic       point_right;
  logic [3:0] score_left;
  logic [7:0] score_right;
  logic       left_blank;
  logic       ball_run;
  logic       game_over;
  logic       winner;
  logic [1:0] dbg_state;

  // Controller side: receives pulses, drives the score/status outputs.
  modport slave (
    input  start, point_left, point_right,
    output score_left, score_right, left_blank, ball_run, game_over,
           winner, dbg_state
  );

  // Environment side: drives pulses, observes the controller.
  modport master (
    output start, point_left, point_right,
    input  score_left, score_right, left_blank, ball_run, game_over,
           winner, dbg_state
  );
endinterface

// File: rtl/pong_score_controller.sv
// Pong match sequencer: counts points, pauses for a serve after each
// point, detects the winner and blinks the winner's score until the
// next start. score_right uses the display's ">=100 blanks" rule (255).
module pong_score_controller #(
  parameter int WIN_SCORE    = 7,          // 1..15
  parameter int SERVE_CYCLES = 50_000_000, // >= 1
  parameter int BLINK_CYCLES = 25_000_000  // >= 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  pong_score_controller_if.slave  bus
);

  localparam int SW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);
  localparam logic [7:0]    BLANK_VAL = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] serve_cnt_q, serve_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    score_l_q, score_l_d;
  logic [3:0]    score_r_q, score_r_d;
  logic          winner_q, winner_d;
  logic          ball_run_q, ball_run_d;
  logic          game_over_q, game_over_d;
  logic          left_blank_q, left_blank_d;
  logic [7:0]    disp_r_q, disp_r_d;
  logic [3:0]    inc_l, inc_r;

  // Saturating increments; WIN_SCORE <= 15 means saturation never bites
  // in a legal configuration, but the counters still never wrap.
  assign inc_l = (score_l_q == 4'hF) ? 4'hF : score_l_q + 4'd1;
  assign inc_r = (score_r_q == 4'hF) ? 4'hF : score_r_q + 4'd1;

  // Next-state, counter and registered-output logic for the match FSM.
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;

    case (state_q)
      ST_IDLE: begin
        score_l_d = 4'd0;
        score_r_d = 4'd0;
        if (bus.start) begin
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
        end
      end

      ST_SERVE: begin
        // Points and start are deliberately ignored while serving.
        if (serve_cnt_q == SERVE_LAST) begin
          state_d     = ST_PLAY;
          serve_cnt_d = '0;
        end else begin
          serve_cnt_d = serve_cnt_q + SW'(1);
        end
      end

      ST_PLAY: begin
        if (bus.point_left && bus.point_right) begin
          // Simultaneous pulses: void rally, re-serve without scoring.
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
        end else if (bus.point_left || bus.point_right) begin
          if (bus.point_left) score_l_d = inc_l;
          else                score_r_d = inc_r;
          if ((bus.point_left && inc_l == WIN) ||
              (bus.point_right && inc_r == WIN)) begin
            state_d     = ST_OVER;
            winner_d    = bus.point_right;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end else begin
            state_d     = ST_SERVE;
            serve_cnt_d = '0;
          end
        end
      end

      ST_OVER: begin
        if (bus.start) begin
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          winner_d    = 1'b0;
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        serve_cnt_d = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        score_l_d   = 4'd0;
        score_r_d   = 4'd0;
        winner_d    = 1'b0;
      end
    endcase

    // Outputs are computed from next-state values so that the registered
    // copies line up with the state they describe.
    ball_run_d   = (state_d == ST_PLAY);
    game_over_d  = (state_d == ST_OVER);
    left_blank_d = (state_d == ST_OVER) && phase_d && !winner_d;
    disp_r_d     = ((state_d == ST_OVER) && phase_d && winner_d) ?
                   BLANK_VAL : {4'd0, score_r_d};
  end

  // State, counters and output registers; reset returns to IDLE values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      serve_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      winner_q     <= 1'b0;
      ball_run_q   <= 1'b0;
      game_over_q  <= 1'b0;
      left_blank_q <= 1'b0;
      disp_r_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      serve_cnt_q  <= serve_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      ball_run_q   <= ball_run_d;
      game_over_q  <= game_over_d;
      left_blank_q <= left_blank_d;
      disp_r_q     <= disp_r_d;
    end
  end

  assign bus.score_left  = score_l_q;
  assign bus.score_right = disp_r_q;
  assign bus.left_blank  = left_blank_q;
  assign bus.ball_run    = ball_run_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pong_score_controller.sv
// Bench for pong_score_controller with WIN_SCORE=3, SERVE_CYCLES=4,
// BLINK_CYCLES=8. Expected output words are
// {score_left, score_right, ball_run, game_over, winner, left_blank}.
module tb_pong_score_controller;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   failures;
  logic [15:0] exp_q[$];

  pong_score_controller_if bus();

  pong_score_controller #(
    .WIN_SCORE   (3),
    .SERVE_CYCLES(4),
    .BLINK_CYCLES(8)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        s;
    logic        pl;
    logic        pr;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[27];

  function automatic logic [15:0] pk(input int sl, input int sr, input int br,
                                     input int go, input int w, input int lb);
    return {sl[3:0], sr[7:0], br[0], go[0], w[0], lb[0]};
  endfunction

  // Scoreboard: pop one expected word and compare with current outputs.
  task automatic check_out(input string name);
    logic [15:0] act;
    logic [15:0] e;
    act = {bus.score_left, bus.score_right, bus.ball_run, bus.game_over,
           bus.winner, bus.left_blank};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    checks++;
    if (bus.dbg_state !== exp) begin
      failures++;
      $display("FAIL %s: state got %0d expected %0d", name, bus.dbg_state, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, then check the post-edge outputs.
  task automatic step(input logic s, input logic pl, input logic pr,
                      input logic [15:0] exp, input string name);
    bus.start       = s;
    bus.point_left  = pl;
    bus.point_right = pr;
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    bus.start       = 1'b0;
    bus.point_left  = 1'b0;
    bus.point_right = 1'b0;
    check_out(name);
  endtask

  // Remaining serve cycles after the entering edge: 3 idle, then running.
  task automatic serve_rest(input int sl, input int sr, input string name);
    for (int k = 0; k < 3; k++) step(0, 0, 0, pk(sl, sr, 0, 0, 0, 0), name);
    step(0, 0, 0, pk(sl, sr, 1, 0, 0, 0), name);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.start       = 1'b0;
    bus.point_left  = 1'b0;
    bus.point_right = 1'b0;

    tbl[0]  = '{1, 0, 0, pk(0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{0, 0, 0, pk(0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{0, 0, 0, pk(0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{0, 0, 0, pk(0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{0, 0, 0, pk(0, 0, 1, 0, 0, 0)};
    tbl[5]  = '{0, 1, 0, pk(1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{0, 0, 0, pk(1, 0, 0, 0, 0, 0)};
    tbl[7]  = '{0, 0, 0, pk(1, 0, 0, 0, 0, 0)};
    tbl[8]  = '{0, 0, 0, pk(1, 0, 0, 0, 0, 0)};
    tbl[9]  = '{0, 0, 0, pk(1, 0, 1, 0, 0, 0)};
    tbl[10] = '{0, 1, 1, pk(1, 0, 0, 0, 0, 0)};
    tbl[11] = '{0, 0, 1, pk(1, 0, 0, 0, 0, 0)};
    tbl[12] = '{1, 0, 0, pk(1, 0, 0, 0, 0, 0)};
    tbl[13] = '{0, 0, 0, pk(1, 0, 0, 0, 0, 0)};
    tbl[14] = '{0, 0, 0, pk(1, 0, 1, 0, 0, 0)};
    tbl[15] = '{0, 0, 1, pk(1, 1, 0, 0, 0, 0)};
    tbl[16] = '{0, 0, 0, pk(1, 1, 0, 0, 0, 0)};
    tbl[17] = '{0, 0, 0, pk(1, 1, 0, 0, 0, 0)};
    tbl[18] = '{0, 0, 0, pk(1, 1, 0, 0, 0, 0)};
    tbl[19] = '{0, 0, 0, pk(1, 1, 1, 0, 0, 0)};
    tbl[20] = '{1, 0, 0, pk(1, 1, 1, 0, 0, 0)};
    tbl[21] = '{0, 0, 1, pk(1, 2, 0, 0, 0, 0)};
    tbl[22] = '{0, 0, 0, pk(1, 2, 0, 0, 0, 0)};
    tbl[23] = '{0, 0, 0, pk(1, 2, 0, 0, 0, 0)};
    tbl[24] = '{0, 0, 0, pk(1, 2, 0, 0, 0, 0)};
    tbl[25] = '{0, 0, 0, pk(1, 2, 1, 0, 0, 0)};
    tbl[26] = '{0, 0, 1, pk(1, 3, 0, 1, 1, 0)};

    // Reset
    Reset_n = 1'b0;
    #12;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    check_out("reset_outputs");
    check_state("reset_state", 2'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    step(0, 1, 1, pk(0, 0, 0, 0, 0, 0), "idle_ignores_points");

    // First match: serve timing, single point, void rally, ignored pulses,
    // right reaches the winning score.
    for (int i = 0; i < 27; i++) begin
      step(tbl[i].s, tbl[i].pl, tbl[i].pr, tbl[i].exp, $sformatf("tbl_row%0d", i));
    end
    check_state("state_game_over", 2'd3);

    // Right-winner blink: 3 for 8 cycles, 255 for 8, and so on.
    for (int i = 1; i <= 20; i++) begin
      step(0, (i == 3), (i == 5),
           pk(1, (((i / 8) % 2) == 1) ? 255 : 3, 0, 1, 1, 0),
           $sformatf("blink_right_%0d", i));
    end

    // Restart from GAME_OVER, then left wins three straight points.
    step(1, 0, 0, pk(0, 0, 0, 0, 0, 0), "restart_1");
    serve_rest(0, 0, "restart_1_serve");
    check_state("state_play", 2'd2);
    for (int k = 1; k <= 2; k++) begin
      step(0, 1, 0, pk(k, 0, 0, 0, 0, 0), "left_point");
      serve_rest(k, 0, "left_serve");
    end
    step(0, 1, 0, pk(3, 0, 0, 1, 0, 0), "left_wins");
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, pk(3, 0, 0, 1, 0, ((i / 8) % 2)),
           $sformatf("blink_left_%0d", i));
    end

    // Restart, right wins again, reset asynchronously while blanked.
    step(1, 0, 0, pk(0, 0, 0, 0, 0, 0), "restart_2");
    serve_rest(0, 0, "restart_2_serve");
    for (int k = 1; k <= 2; k++) begin
      step(0, 0, 1, pk(0, k, 0, 0, 0, 0), "right_point");
      serve_rest(0, k, "right_serve");
    end
    step(0, 0, 1, pk(0, 3, 0, 1, 1, 0), "right_wins");
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 0, pk(0, (i >= 8) ? 255 : 3, 0, 1, 1, 0),
           $sformatf("blink_pre_reset_%0d", i));
    end
    #2;
    Reset_n = 1'b0;
    #1;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    check_out("async_reset_mid_blink");
    check_state("async_reset_state", 2'd0);

    // Pulses during reset are not remembered.
    bus.start      = 1'b1;
    bus.point_left = 1'b1;
    @(posedge Clk);
    #1;
    bus.start      = 1'b0;
    bus.point_left = 1'b0;
    Reset_n        = 1'b1;
    step(0, 0, 0, pk(0, 0, 0, 0, 0, 0), "post_reset_idle");
    check_state("post_reset_state", 2'd0);

    // Normal start after reset.
    step(1, 0, 0, pk(0, 0, 0, 0, 0, 0), "start_after_reset");
    serve_rest(0, 0, "start_after_reset_serve");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
